// File: rtl/prog_mod_counter.sv
// ---------------------------------------------------------------------------
// prog_mod_counter
//   Mod-M up/down counter. The modulus M can be reprogrammed at run time,
//   the count can be loaded in parallel, and the end-of-range behaviour is
//   selectable: wrap, saturate or one-shot.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_en        count enable
//   i_up_down   1 = up, 0 = down
//   i_mode      00/11 wrap, 01 saturate, 10 one-shot
//   i_mod_wr    modulus write strobe
//   i_mod       new modulus (WIDTH+1 bits, legal 2..2^WIDTH)
//   i_load      synchronous load strobe
//   i_load_val  load value
//   o_Q         count value, always 0..M-1
//   o_tc        terminal count (combinational, cascade carry)
//   o_wrap      one-cycle pulse after a wrap
//   o_done      sticky one-shot completion
//   o_err       one-cycle pulse after an illegal modulus or load request
// ---------------------------------------------------------------------------
module prog_mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_RST = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_down,
  input  logic [1:0]       i_mode,
  input  logic             i_mod_wr,
  input  logic [WIDTH:0]   i_mod,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_done,
  output logic             o_err
);

  // Modulus arithmetic is one bit wider than the count so M = 2^WIDTH fits.
  localparam int unsigned MW = WIDTH + 1;
  localparam logic [MW-1:0] M_MAX   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [MW-1:0] M_MIN   = MW'(2);
  localparam logic [MW-1:0] M_RESET = MW'(N_RST);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;

  // Reject illegal parameterisations at elaboration time.
  if (WIDTH < 2) begin : g_bad_width
    $error("prog_mod_counter: WIDTH must be at least 2");
  end
  if ((N_RST < 2) || (N_RST > (1 << WIDTH))) begin : g_bad_nrst
    $error("prog_mod_counter: N_RST must lie in 2..2^WIDTH");
  end

  logic [WIDTH-1:0] q;
  logic [MW-1:0]    m;
  logic             wrap;
  logic             done;
  logic             err;

  logic [WIDTH-1:0] q_nxt;
  logic [MW-1:0]    m_nxt;
  logic             wrap_nxt;
  logic             done_nxt;
  logic             err_nxt;

  logic [MW-1:0]    m_last;
  logic             at_term;
  logic             mod_ok;
  logic             load_ok;

  // Range decode shared by the next-state logic and o_tc.
  always_comb begin
    m_last  = m - MW'(1);
    at_term = i_up_down ? ({1'b0, q} == m_last) : (q == '0);
    mod_ok  = (i_mod >= M_MIN) && (i_mod <= M_MAX);
    load_ok = ({1'b0, i_load_val} < m);
  end

  // Next state: valid modulus write > load > count > hold.
  always_comb begin
    q_nxt    = q;
    m_nxt    = m;
    wrap_nxt = 1'b0;
    done_nxt = done;
    err_nxt  = 1'b0;

    // An illegal write only flags; the rest of the cycle proceeds normally.
    if (i_mod_wr && !mod_ok) begin
      err_nxt = 1'b1;
    end

    if (i_mod_wr && mod_ok) begin
      m_nxt    = i_mod;
      q_nxt    = '0;
      done_nxt = 1'b0;
    end else if (i_load) begin
      if (load_ok) begin
        q_nxt = i_load_val;
      end else begin
        q_nxt   = WIDTH'(m_last);
        err_nxt = 1'b1;
      end
      done_nxt = 1'b0;
    end else if (i_en && !done) begin
      if (!at_term) begin
        q_nxt = i_up_down ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end else begin
        case (i_mode)
          MODE_SAT:  q_nxt = q;
          MODE_ONCE: done_nxt = 1'b1;
          default: begin
            q_nxt    = i_up_down ? '0 : WIDTH'(m_last);
            wrap_nxt = 1'b1;
          end
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q    <= '0;
      m    <= M_RESET;
      wrap <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_nxt;
      m    <= m_nxt;
      wrap <= wrap_nxt;
      done <= done_nxt;
      err  <= err_nxt;
    end
  end

  assign o_Q    = q;
  assign o_wrap = wrap;
  assign o_done = done;
  assign o_err  = err;
  assign o_tc   = i_en & ~done & at_term;

endmodule

// File: tb/tb_prog_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_mod_counter
//   Scoreboard bench for prog_mod_counter (WIDTH=4, N_RST=10). Each cycle the
//   bench drives inputs, predicts the post-edge state with a small model,
//   pushes it to a queue, and pops/compares after the edge.
// ---------------------------------------------------------------------------
module tb_prog_mod_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N_RST = 10;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_en;
  logic             i_up_down;
  logic [1:0]       i_mode;
  logic             i_mod_wr;
  logic [WIDTH:0]   i_mod;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic [WIDTH-1:0] o_Q;
  logic             o_tc;
  logic             o_wrap;
  logic             o_done;
  logic             o_err;

  prog_mod_counter #(.WIDTH(WIDTH), .N_RST(N_RST)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_up_down  (i_up_down),
    .i_mode     (i_mode),
    .i_mod_wr   (i_mod_wr),
    .i_mod      (i_mod),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .o_Q        (o_Q),
    .o_tc       (o_tc),
    .o_wrap     (o_wrap),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int q;
    int wrap;
    int done;
    int err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step_n = 0;

  // Reference model state.
  int mq;
  int mm;
  int mdone;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq    = 0;
    mm    = N_RST;
    mdone = 0;
  endtask

  // Drive one cycle, check o_tc before the edge and the registered state after.
  task automatic tick(input int en, input int ud, input int md, input int mw,
                      input int mv, input int ld, input int lv);
    exp_t e;
    int   nq, nm, nd, nw, ne, term, legal;
    i_en       = 1'(en);
    i_up_down  = 1'(ud);
    i_mode     = 2'(md);
    i_mod_wr   = 1'(mw);
    i_mod      = (WIDTH+1)'(mv);
    i_load     = 1'(ld);
    i_load_val = WIDTH'(lv);
    #1;
    term = ud ? (mq == mm - 1) : (mq == 0);
    check($sformatf("tc@%0d", step_n), int'(o_tc), (en != 0 && mdone == 0 && term != 0) ? 1 : 0);

    nq = mq; nm = mm; nd = mdone; nw = 0; ne = 0;
    legal = (mv >= 2) && (mv <= (1 << WIDTH));
    if (mw != 0 && legal == 0) ne = 1;
    if (mw != 0 && legal != 0) begin
      nm = mv; nq = 0; nd = 0;
    end else if (ld != 0) begin
      if (lv < mm) nq = lv;
      else begin nq = mm - 1; ne = 1; end
      nd = 0;
    end else if (en != 0 && mdone == 0) begin
      if (term == 0) nq = ud ? mq + 1 : mq - 1;
      else if (md == 1) nq = mq;
      else if (md == 2) nd = 1;
      else begin nq = ud ? 0 : mm - 1; nw = 1; end
    end
    mq = nq; mm = nm; mdone = nd;
    e.q = nq; e.wrap = nw; e.done = nd; e.err = ne;
    sb.push_back(e);

    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("sb_empty@%0d", step_n), 0, 1);
    end else begin
      e = sb.pop_front();
      check($sformatf("q@%0d", step_n),    int'(o_Q),    e.q);
      check($sformatf("wrap@%0d", step_n), int'(o_wrap), e.wrap);
      check($sformatf("done@%0d", step_n), int'(o_done), e.done);
      check($sformatf("err@%0d", step_n),  int'(o_err),  e.err);
    end
    step_n++;
  endtask

  // Count only: en, up/down, mode.
  task automatic cnt(input int en, input int ud, input int md);
    tick(en, ud, md, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_up_down = 1'b1; i_mode = 2'b00;
    i_mod_wr = 1'b0; i_mod = '0; i_load = 1'b0; i_load_val = '0;
    model_reset();
    #12;
    check("rst_q",    int'(o_Q),    0);
    check("rst_wrap", int'(o_wrap), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err",  int'(o_err),  0);
    #11;
    i_rst = 1'b0;

    // Count to 6, then reset between edges.
    for (int i = 0; i < 6; i++) cnt(1, 1, 0);
    check("pre_rst_q", int'(o_Q), 6);
    i_rst = 1'b1;
    #1;
    check("async_rst_q", int'(o_Q), 0);
    #2;
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) cnt(1, 1, 0);
    check("post_rst_q", int'(o_Q), 2);

    // Wrap up and down.
    tick(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cnt(1, 1, 0);
    check("wrap_up_q", int'(o_Q), 0);
    check("wrap_up_pulse", int'(o_wrap), 1);
    cnt(0, 1, 0);
    for (int i = 0; i < 2; i++) cnt(1, 0, 3);
    check("wrap_dn_q", int'(o_Q), 8);

    // Modulus programming.
    tick(0, 1, 0, 0, 0, 1, 7);
    tick(1, 1, 0, 1, 3, 0, 0);
    check("mod3_q", int'(o_Q), 0);
    for (int i = 0; i < 4; i++) cnt(1, 1, 0);
    tick(1, 1, 0, 1, 1, 0, 0);
    check("mod1_err", int'(o_err), 1);
    tick(1, 1, 0, 1, 17, 0, 0);
    check("mod17_err", int'(o_err), 1);
    for (int i = 0; i < 3; i++) cnt(1, 1, 0);
    tick(1, 1, 0, 1, 16, 0, 0);
    for (int i = 0; i < 15; i++) cnt(1, 1, 0);
    check("mod16_top", int'(o_Q), 15);
    cnt(1, 1, 0);
    tick(0, 1, 0, 1, 10, 0, 0);

    // Saturate.
    for (int i = 0; i < 12; i++) cnt(1, 1, 1);
    check("sat_q", int'(o_Q), 9);

    // One-shot, then clear by load.
    for (int i = 0; i < 2; i++) cnt(1, 1, 2);
    check("once_done", int'(o_done), 1);
    for (int i = 0; i < 4; i++) cnt(i % 2, 1, 2);
    tick(1, 1, 2, 0, 0, 1, 4);
    check("once_clr_q", int'(o_Q), 4);

    // Load rules.
    tick(0, 1, 0, 0, 0, 1, 12);
    check("ld12_q", int'(o_Q), 9);
    tick(1, 1, 0, 0, 0, 1, 5);
    cnt(1, 1, 0);
    check("ld5_next", int'(o_Q), 6);
    tick(1, 1, 0, 1, 12, 1, 3);
    check("wr_beats_ld", int'(o_Q), 0);
    tick(0, 1, 0, 1, 10, 0, 0);

    // Direction change at the terminal value.
    tick(0, 1, 0, 0, 0, 1, 9);
    cnt(1, 0, 0);
    check("dir_chg_q", int'(o_Q), 8);

    // Randomised mix.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0) ? 1 : 0, int'($urandom_range(0, 17)),
           ($urandom_range(0, 11) == 0) ? 1 : 0, int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_mod_counter.md
Name: prog_mod_counter

Overview:
Next-generation mod-N up/down counter with a runtime-programmable modulus, synchronous parallel load, and selectable end-of-range mode (wrap, saturate, one-shot). Provides terminal-count and wrap outputs for cascading and event signalling. Replaces the fixed-modulus counter in timer and sequencing paths.

Parameters:
WIDTH, 4, counter width in bits; must be at least 2
N_RST, 10, modulus loaded at reset; legal range 2..2^WIDTH, checked at elaboration

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  count enable
i_up_down  in  1  1 = count up, 0 = count down
i_mode  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap
i_mod_wr  in  1  modulus write strobe
i_mod  in  WIDTH+1  new modulus value
i_load  in  1  synchronous load strobe
i_load_val  in  WIDTH  load value
o_Q  out  WIDTH  count value
o_tc  out  1  terminal count, combinational
o_wrap  out  1  registered one-cycle wrap pulse
o_done  out  1  one-shot complete, sticky
o_err  out  1  registered one-cycle illegal-request pulse

Behaviour:
- Reset (async, any time, including mid-operation): o_Q=0, M=N_RST, o_wrap=0, o_done=0, o_err=0. The first count occurs on the first rising edge after i_rst deasserts.
- M is the internal modulus register. The count range is 0..M-1.
- Per-edge priority: valid modulus write > load > count > hold.
- Modulus write:
  - Valid when 2 <= i_mod <= 2^WIDTH: M<=i_mod, o_Q<=0, o_done<=0. Any i_load or count in the same cycle is discarded.
  - Illegal value: M unchanged, o_err pulses, and the cycle proceeds as if i_mod_wr were 0 (load or count still applies).
- Load (i_load=1, no valid modulus write):
  - i_load_val < M: o_Q<=i_load_val.
  - Otherwise: o_Q<=M-1 and o_err pulses.
  - o_done<=0 in both cases.
  - Load takes effect regardless of i_en.
- Terminal value: M-1 when counting up, 0 when counting down.
- Count (i_en=1, no load or write, o_done=0):
  - Up, not at terminal: o_Q<=o_Q+1.
  - Down, not at terminal: o_Q<=o_Q-1.
  - At terminal, wrap mode: o_Q<=0 (up) or M-1 (down), and o_wrap=1 for the following cycle.
  - At terminal, saturate mode: hold; no o_wrap.
  - At terminal, one-shot mode: hold and set o_done<=1.
- o_done=1 blocks counting. It clears only on load, valid modulus write, or reset.
- i_en=0: o_Q holds. i_up_down and i_mode may change on any cycle; the new value applies on the next edge.
- o_tc = i_en & ~o_done & (o_Q == terminal value). It is combinational, for carry-in of a cascaded stage. It is asserted in every mode.
- o_wrap and o_err are single-cycle pulses. Back-to-back events give back-to-back pulses.
- Arithmetic is WIDTH+1 bits internally so that M=2^WIDTH is representable. o_Q never exceeds M-1.

Test Plan:
- Reset mid-count: WIDTH=4, N_RST=10, o_Q=6, assert i_rst between edges -> o_Q=0 immediately with no edge; after release, up-count gives 0,1,2.
- Wrap both directions: up from 0 for 10 edges -> 1..9,0; o_tc high while o_Q=9; o_wrap high exactly one cycle after 9->0. Down from 0 -> 9,8; o_wrap pulses once.
- Modulus programming:
  - Write 3 at o_Q=7 -> o_Q=0, then sequence 0,1,2,0.
  - Write 1 or 17 -> o_err pulses, M stays 3, counting continues.
  - Write 16 -> full 0..15 range.
- Saturate and one-shot:
  - Mode 01 up -> holds at 9, o_wrap stays 0.
  - Mode 10 up -> holds at 9, o_done=1, o_tc=0; toggling i_en changes nothing.
  - Load 4 -> o_done=0, o_Q=4.
- Load rules:
  - M=10, load 12 -> o_Q=9 and o_err pulses.
  - Load 5 with i_en=1 -> o_Q=5; counting resumes next edge.
  - Load and valid modulus write in the same cycle -> write wins, o_Q=0.
- Direction change at terminal: wrap mode, o_Q=9, i_up_down switched 1->0 at the same edge -> o_Q=8, no o_wrap.
